// File: rtl/sm_drv_pkg.sv
// Shared state encoding and default timing for the stepper STEP/DIR/EN conditioner.
package sm_drv_pkg;

  localparam int unsigned T_WAKE_DEF      = 50000;
  localparam int unsigned T_DIR_SETUP_DEF = 25;
  localparam int unsigned T_PULSE_HI_DEF  = 100;
  localparam int unsigned T_PULSE_LO_DEF  = 100;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned POS_W_DEF       = 32;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_WAKE      = 3'd1,
    ST_IDLE      = 3'd2,
    ST_DIR_SETUP = 3'd3,
    ST_STEP_HIGH = 3'd4,
    ST_STEP_LOW  = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs (limit switches).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sm_step_conditioner.sv
// Turns raw step/dir/enable requests into driver-IC-legal STEP/DIR/EN_n timing,
// with a one-deep request queue, limit-switch blocking and a position counter.
module sm_step_conditioner
  import sm_drv_pkg::*;
#(
  parameter int unsigned T_WAKE      = T_WAKE_DEF,
  parameter int unsigned T_DIR_SETUP = T_DIR_SETUP_DEF,
  parameter int unsigned T_PULSE_HI  = T_PULSE_HI_DEF,
  parameter int unsigned T_PULSE_LO  = T_PULSE_LO_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned POS_W       = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_en_SM,
  input  logic                    limit_fwd,
  input  logic                    limit_rev,
  output logic                    sm_step,
  output logic                    sm_dir,
  output logic                    sm_en_n,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    step_dropped,
  output logic                    limit_hit
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic               r_pending;
  logic               r_pend_dir;
  logic               r_dis_req;
  logic               r_step_q;
  logic               r_sm_step;
  logic               r_sm_dir;
  logic               r_sm_en_n;
  logic [POS_W-1:0]   r_position;
  logic               r_busy;
  logic               r_dropped;
  logic               r_limit_hit;

  logic               w_lim_fwd;
  logic               w_lim_rev;
  logic               w_step_req;
  logic               w_timer_done;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic               w_pending_nxt;
  logic               w_pend_dir_nxt;
  logic               w_dis_req_nxt;
  logic               w_dir_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_dropped_nxt;
  logic               w_limit_hit_nxt;
  logic               w_svc_pt;
  logic               w_svc;
  logic               w_svc_dir;
  logic               w_req_used;
  logic               w_pend_used;
  logic               w_enter_high;

  sync_2ff u_sync_fwd (.clk(clk), .rst(rst), .i_d(limit_fwd), .o_q(w_lim_fwd));
  sync_2ff u_sync_rev (.clk(clk), .rst(rst), .i_d(limit_rev), .o_q(w_lim_rev));

  assign w_step_req   = drv_step & ~r_step_q;
  assign w_timer_done = (r_timer == '0);

  // Next-state, timer, queue and event logic
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_pending_nxt   = r_pending;
    w_pend_dir_nxt  = r_pend_dir;
    w_dis_req_nxt   = r_dis_req;
    w_dir_nxt       = r_sm_dir;
    w_pos_nxt       = r_position;
    w_dropped_nxt   = 1'b0;
    w_limit_hit_nxt = 1'b0;
    w_svc_pt        = 1'b0;
    w_svc           = 1'b0;
    w_svc_dir       = 1'b0;
    w_req_used      = 1'b0;
    w_pend_used     = 1'b0;
    w_enter_high    = 1'b0;

    case (r_state)
      ST_DISABLED: begin
        if (drv_en_SM) begin
          w_state_nxt = ST_WAKE;
          w_timer_nxt = CNT_W'(T_WAKE - 1);
        end
      end
      ST_WAKE: begin
        if (!drv_en_SM)        w_state_nxt = ST_DISABLED;
        else if (w_timer_done) w_svc_pt    = 1'b1;
        else                   w_timer_nxt = r_timer - CNT_W'(1);
      end
      ST_IDLE: begin
        if (!drv_en_SM) w_state_nxt = ST_DISABLED;
        else            w_svc_pt    = 1'b1;
      end
      ST_DIR_SETUP: begin
        if (!drv_en_SM)        w_state_nxt  = ST_DISABLED;
        else if (w_timer_done) w_enter_high = 1'b1;
        else                   w_timer_nxt  = r_timer - CNT_W'(1);
      end
      ST_STEP_HIGH: begin
        // The high phase always completes; a disable only redirects the exit.
        if (!drv_en_SM) w_dis_req_nxt = 1'b1;
        if (w_timer_done) begin
          if (!drv_en_SM || r_dis_req) begin
            w_state_nxt = ST_DISABLED;
          end else begin
            w_state_nxt = ST_STEP_LOW;
            w_timer_nxt = CNT_W'(T_PULSE_LO - 1);
          end
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      ST_STEP_LOW: begin
        if (!drv_en_SM)        w_state_nxt = ST_DISABLED;
        else if (w_timer_done) w_svc_pt    = 1'b1;
        else                   w_timer_nxt = r_timer - CNT_W'(1);
      end
      default: w_state_nxt = ST_DISABLED;
    endcase

    // Service point: the pending step goes first, else a same-cycle request.
    if (w_svc_pt) begin
      w_state_nxt = ST_IDLE;
      if (r_pending) begin
        w_svc       = 1'b1;
        w_svc_dir   = r_pend_dir;
        w_pend_used = 1'b1;
      end else if (w_step_req) begin
        w_svc      = 1'b1;
        w_svc_dir  = drv_dir;
        w_req_used = 1'b1;
      end
    end

    if (w_svc) begin
      if (w_svc_dir ? w_lim_fwd : w_lim_rev) begin
        w_limit_hit_nxt = 1'b1;
      end else if (w_svc_dir != r_sm_dir) begin
        w_state_nxt = ST_DIR_SETUP;
        w_dir_nxt   = w_svc_dir;
        w_timer_nxt = CNT_W'(T_DIR_SETUP - 1);
      end else begin
        w_enter_high = 1'b1;
      end
    end

    // sm_dir already equals the step direction whenever STEP_HIGH is entered.
    if (w_enter_high) begin
      w_state_nxt = ST_STEP_HIGH;
      w_timer_nxt = CNT_W'(T_PULSE_HI - 1);
      w_pos_nxt   = r_sm_dir ? r_position + POS_W'(1) : r_position - POS_W'(1);
    end

    if (w_pend_used) w_pending_nxt = 1'b0;

    if (w_step_req && !w_req_used && drv_en_SM && !r_dis_req &&
        (r_state != ST_DISABLED)) begin
      if (!r_pending || w_pend_used) begin
        w_pending_nxt  = 1'b1;
        w_pend_dir_nxt = drv_dir;
      end else begin
        w_dropped_nxt = 1'b1;
      end
    end

    if (!drv_en_SM) w_pending_nxt = 1'b0;

    if (w_state_nxt == ST_DISABLED) begin
      w_pending_nxt = 1'b0;
      w_dis_req_nxt = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DISABLED;
      r_timer     <= '0;
      r_pending   <= 1'b0;
      r_pend_dir  <= 1'b0;
      r_dis_req   <= 1'b0;
      r_step_q    <= 1'b0;
      r_sm_step   <= 1'b0;
      r_sm_dir    <= 1'b0;
      r_sm_en_n   <= 1'b1;
      r_position  <= '0;
      r_busy      <= 1'b0;
      r_dropped   <= 1'b0;
      r_limit_hit <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_dir  <= w_pend_dir_nxt;
      r_dis_req   <= w_dis_req_nxt;
      r_step_q    <= drv_step;
      r_sm_step   <= (w_state_nxt == ST_STEP_HIGH);
      r_sm_dir    <= w_dir_nxt;
      r_sm_en_n   <= (w_state_nxt == ST_DISABLED);
      r_position  <= w_pos_nxt;
      r_busy      <= ((w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DISABLED)) ||
                     w_pending_nxt;
      r_dropped   <= w_dropped_nxt;
      r_limit_hit <= w_limit_hit_nxt;
    end
  end

  assign sm_step      = r_sm_step;
  assign sm_dir       = r_sm_dir;
  assign sm_en_n      = r_sm_en_n;
  assign position     = $signed(r_position);
  assign busy         = r_busy;
  assign step_dropped = r_dropped;
  assign limit_hit    = r_limit_hit;

endmodule
